// File: rtl/cnt_cmd_sched_if.sv
// Command/status bundle between the LED counter scheduler and its requesters.
// The SAT line exists only when CNT_SAT_EN is defined.
interface cnt_cmd_sched_if #(
    parameter int WIDTH = 10
);
    logic [5:0]       req;
    logic             run_en;
    logic [WIDTH-1:0] count;
    logic [5:0]       gnt;
    logic [5:0]       pend;
    logic [1:0]       state;
    logic             tick;
    logic [1:0]       act;
`ifdef CNT_SAT_EN
    logic             sat;

    modport master (output req, run_en, input count, gnt, pend, state, tick, act, sat);
    modport slave  (input req, run_en, output count, gnt, pend, state, tick, act, sat);
`else
    modport master (output req, run_en, input count, gnt, pend, state, tick, act);
    modport slave  (input req, run_en, output count, gnt, pend, state, tick, act);
`endif
endinterface

// File: rtl/cnt_cmd_sched.sv
// Single-clock command scheduler for the LED counter: pending latch, fixed-priority
// grant, tick divider and run/hold/step FSM. Define CNT_SAT_EN for saturating arithmetic.
//
// state  | meaning
// S_RUN  | free-run, advance slot on every TICK
// S_HOLD | counter frozen, waiting for RUN_EN or a STEP request
// S_STEP | perform exactly one advance slot, then back to S_HOLD
module cnt_cmd_sched #(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] PAT_A = 10'h2AA,
    parameter logic [WIDTH-1:0] PAT_B = 10'h155,
    parameter int               DIV_W = 23
) (
    input  logic           CLK,
    input  logic           RST_N,
    cnt_cmd_sched_if.slave bus
);
    localparam int B_CLR  = 0;
    localparam int B_LDA  = 1;
    localparam int B_LDB  = 2;
    localparam int B_SHL  = 3;
    localparam int B_DEC  = 4;
    localparam int B_STEP = 5;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HOLD = 2'd1,
        S_STEP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE, OP_CLR, OP_LDA, OP_LDB, OP_SHL, OP_DEC, OP_INC
    } op_t;

    state_t           state_q, state_d;
    op_t              op;
    logic             slot;
    logic [5:0]       gnt_d, gnt_q, pend_q;
    logic [WIDTH-1:0] count_d, count_q;
    logic [DIV_W-1:0] div_q;
    logic             tick_q;
    logic [1:0]       act_q;
`ifdef CNT_SAT_EN
    logic             sat_d, sat_q;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            act_q  <= 2'd0;
        end else begin
            div_q  <= div_q + DIV_ONE;
            tick_q <= (div_q == '1);
            if (div_q == '1)
                act_q <= act_q + 2'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            state_q <= S_HOLD;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (!bus.run_en) state_d = S_HOLD;
            S_HOLD:  begin
                if (bus.run_en)
                    state_d = S_RUN;
                else if (gnt_d[B_STEP])
                    state_d = S_STEP;
            end
            S_STEP:  if (slot) state_d = S_HOLD;
            default: state_d = S_HOLD;
        endcase
    end

    // Loads pre-empt any advance slot; a slot lost to a load is not retried.
    always_comb begin
        gnt_d = '0;
        op    = OP_NONE;
        slot  = 1'b0;
        if (pend_q[B_CLR]) begin
            gnt_d[B_CLR] = 1'b1;
            op           = OP_CLR;
        end else if (pend_q[B_LDA]) begin
            gnt_d[B_LDA] = 1'b1;
            op           = OP_LDA;
        end else if (pend_q[B_LDB]) begin
            gnt_d[B_LDB] = 1'b1;
            op           = OP_LDB;
        end else begin
            slot = ((state_q == S_RUN) && tick_q) || (state_q == S_STEP);
            if (slot) begin
                if (pend_q[B_SHL]) begin
                    gnt_d[B_SHL] = 1'b1;
                    op           = OP_SHL;
                end else if (pend_q[B_DEC]) begin
                    gnt_d[B_DEC] = 1'b1;
                    op           = OP_DEC;
                end else begin
                    op = OP_INC;
                end
            end
            // STEP in RUN is simply consumed; in HOLD it launches the step state.
            if ((gnt_d == '0) && pend_q[B_STEP] &&
                ((state_q == S_RUN) || ((state_q == S_HOLD) && !bus.run_en)))
                gnt_d[B_STEP] = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
`ifdef CNT_SAT_EN
        sat_d   = 1'b0;
`endif
        case (op)
            OP_CLR: count_d = '0;
            OP_LDA: count_d = PAT_A;
            OP_LDB: count_d = PAT_B;
`ifdef CNT_SAT_EN
            OP_SHL: begin
                if (count_q[WIDTH-1]) begin
                    count_d = '1;
                    sat_d   = 1'b1;
                end else begin
                    count_d = count_q << 1;
                end
            end
            OP_DEC: begin
                if (count_q == '0)
                    sat_d = 1'b1;
                else
                    count_d = count_q - CNT_ONE;
            end
            OP_INC: begin
                if (count_q == '1)
                    sat_d = 1'b1;
                else
                    count_d = count_q + CNT_ONE;
            end
`else
            OP_SHL: count_d = count_q << 1;
            OP_DEC: count_d = count_q - CNT_ONE;
            OP_INC: count_d = count_q + CNT_ONE;
`endif
            default: count_d = count_q;
        endcase
    end

    // A request arriving on the clearing cycle re-arms the pending bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q  <= '0;
            gnt_q   <= '0;
            count_q <= '0;
        end else begin
            pend_q  <= (pend_q & ~gnt_d) | bus.req;
            gnt_q   <= gnt_d;
            count_q <= count_d;
        end
    end

`ifdef CNT_SAT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            sat_q <= 1'b0;
        else
            sat_q <= sat_d;
    end

    assign bus.sat = sat_q;
`endif

    assign bus.count = count_q;
    assign bus.gnt   = gnt_q;
    assign bus.pend  = pend_q;
    assign bus.state = state_q;
    assign bus.tick  = tick_q;
    assign bus.act   = act_q;
endmodule

// File: tb/tb_cnt_cmd_sched.sv
// Directed bench for cnt_cmd_sched with a short divider; grants are checked
// against a queue of expected (GNT, COUNT) pairs filled as commands are issued.
module tb_cnt_cmd_sched;
    typedef struct {
        logic [5:0] gnt;
        logic [9:0] count;
    } exp_t;

    logic CLK;
    logic RST_N;
    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];

    cnt_cmd_sched_if #(.WIDTH(10)) bus ();

    cnt_cmd_sched #(
        .WIDTH(10),
        .PAT_A(10'h2AA),
        .PAT_B(10'h155),
        .DIV_W(4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] g, input logic [9:0] c);
        exp_t e;
        e.gnt   = g;
        e.count = c;
        exp_q.push_back(e);
    endtask

    // One clock; any grant seen is matched against the scoreboard.
    task automatic cyc();
        exp_t e;
        @(posedge CLK);
        #1;
        if (bus.gnt !== 6'd0) begin
            if (exp_q.size() == 0) begin
                check("gnt_unexpected", {26'd0, bus.gnt}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("gnt", {26'd0, bus.gnt}, {26'd0, e.gnt});
                check("gnt_count", {22'd0, bus.count}, {22'd0, e.count});
            end
        end
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.tick !== 1'b1 && n < 40);
        check("tick_arrives", {31'd0, bus.tick}, 32'd1);
    endtask

    initial begin
        int n;
        n_cmp      = 0;
        n_err      = 0;
        RST_N      = 1'b0;
        bus.req    = 6'd0;
        bus.run_en = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_count", {22'd0, bus.count}, 32'd0);
        check("rst_pend",  {26'd0, bus.pend},  32'd0);
        check("rst_gnt",   {26'd0, bus.gnt},   32'd0);
        check("rst_state", {30'd0, bus.state}, 32'd1);
        check("rst_tick",  {31'd0, bus.tick},  32'd0);
        check("rst_act",   {30'd0, bus.act},   32'd0);

        // Free run: one increment per 16-cycle tick, ACT follows the tick count.
        RST_N      = 1'b1;
        bus.run_en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            wait_tick(n);
            check("tick_period", n, 32'd16);
            check("run_count", {22'd0, bus.count}, k - 1);
            check("run_act", {30'd0, bus.act}, k % 4);
        end
        check("run_state", {30'd0, bus.state}, 32'd0);
        wait_tick(n);
        cyc();
        check("run_count5", {22'd0, bus.count}, 32'd5);

        // CLR and LOAD_A together: serviced on consecutive cycles.
        bus.req = 6'b000011;
        push(6'b000001, 10'h000);
        push(6'b000010, 10'h2AA);
        cyc();
        bus.req = 6'd0;
        check("multi_pend", {26'd0, bus.pend}, 32'h3);
        cyc();
        cyc();
        check("multi_pend_clr", {26'd0, bus.pend}, 32'd0);

        // SHL waits for the next tick slot.
        bus.req = 6'b000100;
        push(6'b000100, 10'h155);
        cyc();
        bus.req = 6'd0;
        cyc();
        bus.req = 6'b001000;
        push(6'b001000, 10'h2AA);
        cyc();
        bus.req = 6'd0;
        wait_tick(n);
        cyc();
        wait_tick(n);
        cyc();
        check("shl_then_inc", {22'd0, bus.count}, 32'h2AB);

        // LOAD_B pending on the tick cycle: the increment is dropped, not deferred.
        bus.req = 6'b000001;
        push(6'b000001, 10'h000);
        cyc();
        bus.req = 6'd0;
        cyc();
        repeat (7) wait_tick(n);
        cyc();
        check("pre_collide", {22'd0, bus.count}, 32'd7);
        repeat (14) cyc();
        bus.req = 6'b000100;
        push(6'b000100, 10'h155);
        cyc();
        bus.req = 6'd0;
        check("collide_tick", {31'd0, bus.tick}, 32'd1);
        check("collide_count", {22'd0, bus.count}, 32'd7);
        cyc();
        cyc();
        check("collide_dropped", {22'd0, bus.count}, 32'h155);
        wait_tick(n);
        cyc();
        check("collide_next", {22'd0, bus.count}, 32'h156);

        // Hold mode: DEC then STEP gives one decrement through the STEP state.
        bus.run_en = 1'b0;
        cyc();
        check("hold_state", {30'd0, bus.state}, 32'd1);
        bus.req = 6'b000001;
        push(6'b000001, 10'h000);
        cyc();
        bus.req = 6'd0;
        cyc();
        bus.req = 6'b010000;
        cyc();
        bus.req = 6'b100000;
        cyc();
        bus.req = 6'd0;
        check("step_pre_state", {30'd0, bus.state}, 32'd1);
        push(6'b100000, 10'h000);
`ifdef CNT_SAT_EN
        push(6'b010000, 10'h000);
`else
        push(6'b010000, 10'h3FF);
`endif
        cyc();
        check("step_state", {30'd0, bus.state}, 32'd2);
        cyc();
        check("step_back_hold", {30'd0, bus.state}, 32'd1);
`ifdef CNT_SAT_EN
        check("step_sat", {31'd0, bus.sat}, 32'd1);
        cyc();
        check("sat_pulse_end", {31'd0, bus.sat}, 32'd0);
`endif
        wait_tick(n);
        wait_tick(n);
        cyc();
`ifdef CNT_SAT_EN
        check("hold_frozen", {22'd0, bus.count}, 32'h000);
`else
        check("hold_frozen", {22'd0, bus.count}, 32'h3FF);
`endif
        check("hold_pend", {26'd0, bus.pend}, 32'd0);

        // Asynchronous reset with SHL and DEC still pending.
        bus.run_en = 1'b1;
        cyc();
        wait_tick(n);
        cyc();
        bus.req = 6'b011010;
        push(6'b000010, 10'h2AA);
        cyc();
        bus.req = 6'd0;
        cyc();
        check("pre_rst_pend", {26'd0, bus.pend}, 32'h18);
        check("pre_rst_count", {22'd0, bus.count}, 32'h2AA);
        RST_N = 1'b0;
        #1;
        check("arst_count", {22'd0, bus.count}, 32'd0);
        check("arst_pend",  {26'd0, bus.pend},  32'd0);
        check("arst_state", {30'd0, bus.state}, 32'd1);
        check("arst_act",   {30'd0, bus.act},   32'd0);
        cyc();
        RST_N = 1'b1;
        cyc();
        cyc();
        check("post_rst_count", {22'd0, bus.count}, 32'd0);
        check("post_rst_pend", {26'd0, bus.pend}, 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
